// File: rtl/slot_tag_dispatcher.sv
// Ingress dispatcher: tags each packet with a free downstream receive slot on tdest
// and recycles slots from release messages arriving on the control channel.
module slot_tag_dispatcher #(
    parameter int DATA_WIDTH = 128,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int PORT_WIDTH = 3,
    parameter int SLOT_COUNT = 16,
    parameter int SLOT_WIDTH = $clog2(SLOT_COUNT + 1),
    parameter int TAG_WIDTH  = (SLOT_WIDTH > 5) ? SLOT_WIDTH : 5,
    parameter int CTRL_WIDTH = 36
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [STRB_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [PORT_WIDTH-1:0] s_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [STRB_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [TAG_WIDTH-1:0]  m_axis_tdest,
    output logic [PORT_WIDTH-1:0] m_axis_tuser,

    input  logic [CTRL_WIDTH-1:0] ctrl_s_axis_tdata,
    input  logic                  ctrl_s_axis_tvalid,
    output logic                  ctrl_s_axis_tready,

    output logic [SLOT_WIDTH-1:0] free_slot_count,
    output logic                  slot_err,
    output logic                  init_done
);

    localparam int PTR_WIDTH = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;
    localparam logic [SLOT_WIDTH-1:0] SLOT_MAX = SLOT_WIDTH'(SLOT_COUNT);
    localparam logic [PTR_WIDTH-1:0]  PTR_LAST = PTR_WIDTH'(SLOT_COUNT - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_PASS
    } state_t;

    state_t                 state;
    logic [SLOT_WIDTH-1:0]  fifo_mem [SLOT_COUNT];
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [SLOT_COUNT-1:0]  busy;
    logic [SLOT_WIDTH-1:0]  cur_slot;

    logic                   ctrl_fire;
    logic                   is_release;
    logic                   rel_in_range;
    logic                   rel_legal;
    logic                   rel_push;
    logic                   rel_bad;
    logic                   pop_fire;
    logic                   pkt_end;
    logic                   init_last;
    logic                   fifo_we;
    logic [SLOT_WIDTH-1:0]  rel_slot;
    logic [SLOT_WIDTH-1:0]  head_slot;
    logic [SLOT_WIDTH-1:0]  init_slot;
    logic [SLOT_WIDTH-1:0]  wr_slot;
    logic [PTR_WIDTH-1:0]   rel_idx;
    logic [PTR_WIDTH-1:0]   head_idx;
    logic                   unused_ctrl_bits;

    function automatic logic [PTR_WIDTH-1:0] ptr_next(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Release path: slot IDs are 1-based, the busy bitmap is 0-based.
    assign ctrl_s_axis_tready = init_done;
    assign ctrl_fire          = ctrl_s_axis_tvalid && init_done;
    assign is_release         = (ctrl_s_axis_tdata[35:32] == 4'h0);
    assign rel_slot           = ctrl_s_axis_tdata[SLOT_WIDTH-1:0];
    assign rel_idx            = PTR_WIDTH'(rel_slot - 1'b1);
    assign rel_in_range       = (rel_slot != '0) && (rel_slot <= SLOT_MAX);
    assign rel_legal          = rel_in_range ? busy[rel_idx] : 1'b0;
    assign rel_push           = ctrl_fire && is_release && rel_legal;
    assign rel_bad            = ctrl_fire && is_release && !rel_legal;
    assign unused_ctrl_bits   = ^ctrl_s_axis_tdata[31:SLOT_WIDTH];

    // Allocation path: a pop needs a non-empty FIFO at the start of the cycle.
    assign head_slot = fifo_mem[rd_ptr];
    assign head_idx  = PTR_WIDTH'(head_slot - 1'b1);
    assign pop_fire  = (state == ST_IDLE) && s_axis_tvalid && (free_slot_count != '0);
    assign pkt_end   = (state == ST_PASS) && s_axis_tvalid && m_axis_tready && s_axis_tlast;

    assign init_slot = free_slot_count + 1'b1;
    assign init_last = (init_slot == SLOT_MAX);
    assign fifo_we   = (state == ST_INIT) || rel_push;
    assign wr_slot   = (state == ST_INIT) ? init_slot : rel_slot;

    // Packet path is a straight wire while a slot is held.
    assign m_axis_tvalid = (state == ST_PASS) && s_axis_tvalid;
    assign s_axis_tready = (state == ST_PASS) && m_axis_tready;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tdest  = TAG_WIDTH'(cur_slot);

    always_ff @(posedge clk) begin
        if (fifo_we) begin
            fifo_mem[wr_ptr] <= wr_slot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_INIT;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            busy            <= '1;
            free_slot_count <= '0;
            cur_slot        <= '0;
            slot_err        <= 1'b0;
            init_done       <= 1'b0;
        end else begin
            if (fifo_we) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop_fire) begin
                rd_ptr         <= ptr_next(rd_ptr);
                busy[head_idx] <= 1'b1;
            end
            if (rel_push) begin
                busy[rel_idx] <= 1'b0;
            end
            if (rel_bad) begin
                slot_err <= 1'b1;
            end

            // Pop and push in the same cycle cancel out in the count.
            if (state == ST_INIT) begin
                free_slot_count <= init_slot;
            end else if (pop_fire && !rel_push) begin
                free_slot_count <= free_slot_count - 1'b1;
            end else if (rel_push && !pop_fire) begin
                free_slot_count <= free_slot_count + 1'b1;
            end

            case (state)
                ST_INIT: begin
                    if (init_last) begin
                        busy      <= '0;
                        init_done <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (pop_fire) begin
                        cur_slot <= head_slot;
                        state    <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (pkt_end) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: doc/slot_tag_dispatcher.md
Name: slot_tag_dispatcher

Overview:
- Ingress stage directly upstream of the Gousheh wrapper's incoming data channel.
- Assigns each incoming packet a free receive slot of the downstream core and drives that slot ID on tdest; stalls packets when no slot is free.
- Reclaims slots from slot-release messages on the wrapper's outgoing control channel.
- Keeps a free-slot FIFO, an in-use bitmap and a free count.

Parameters:
DATA_WIDTH, 128, data bus width in bits
STRB_WIDTH, DATA_WIDTH/8, tkeep width
PORT_WIDTH, 3, ingress port tag width (tuser)
SLOT_COUNT, 16, receive slots in the downstream core; slot IDs are 1..SLOT_COUNT
SLOT_WIDTH, $clog2(SLOT_COUNT+1), slot ID width
TAG_WIDTH, (SLOT_WIDTH>5)?SLOT_WIDTH:5, tdest width
CTRL_WIDTH, 36, control message width (fixed)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
s_axis_tdata  in  DATA_WIDTH  packet data in
s_axis_tkeep  in  STRB_WIDTH  byte enables
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last beat of packet
s_axis_tuser  in  PORT_WIDTH  ingress port
m_axis_tdata  out  DATA_WIDTH  data to wrapper data_s_axis
m_axis_tkeep  out  STRB_WIDTH  byte enables
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  last beat
m_axis_tdest  out  TAG_WIDTH  assigned slot ID, zero-extended
m_axis_tuser  out  PORT_WIDTH  ingress port, passed through
ctrl_s_axis_tdata  in  CTRL_WIDTH  control message from wrapper ctrl_m_axis
ctrl_s_axis_tvalid  in  1  control valid
ctrl_s_axis_tready  out  1  control ready
free_slot_count  out  SLOT_WIDTH  number of free slots
slot_err  out  1  sticky illegal-release flag
init_done  out  1  free FIFO populated

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=INIT, all valids/readies 0, free_slot_count=0, slot_err=0, init_done=0, bitmap all-busy, FIFO pointers 0, cur_slot=0.
- INIT:
  - Writes slot IDs 1..SLOT_COUNT into the FIFO, one per cycle, in ascending order; free_slot_count increments each cycle.
  - After SLOT_COUNT cycles: bitmap all-free, init_done=1, go to IDLE.
  - ctrl_s_axis_tready=0 and s_axis_tready=0 throughout INIT.
- IDLE:
  - s_axis_tready=0, m_axis_tvalid=0.
  - If s_axis_tvalid && free_slot_count!=0: pop FIFO head into cur_slot, mark it busy, decrement the count, go to PASS.
  - Otherwise stay in IDLE. The packet waits; no beat is dropped.
  - This costs one bubble cycle per packet.
- PASS: combinational pass-through.
  - m_axis_tvalid=s_axis_tvalid; s_axis_tready=m_axis_tready.
  - data, keep, last and tuser are forwarded unchanged.
  - m_axis_tdest=cur_slot, stable for every beat of the packet.
  - On a handshake with tlast=1: go to IDLE.
- Release path:
  - ctrl_s_axis_tready=1 whenever init_done=1.
  - A message is a release when tdata[35:32]==4'h0; slot = tdata[SLOT_WIDTH-1:0].
  - Legal release (1<=slot<=SLOT_COUNT and the slot is busy): push the slot to the FIFO tail, mark it free, increment the count.
  - Illegal release (slot 0, slot>SLOT_COUNT, or slot already free): no FIFO or count change; slot_err set to 1 and held until reset.
  - Messages of any other type are consumed and ignored.
- Simultaneous pop and legal push in the same cycle: both happen and free_slot_count is unchanged.
  - A slot released in cycle N is poppable from cycle N+1.
  - A pop is allowed when the count is 0 only if a push happens in the same cycle — NOT allowed; the pop needs count!=0 at the start of the cycle.
- FIFO:
  - Depth SLOT_COUNT, circular pointers with wrap-around.
  - The bitmap guarantees no overflow. An overflow or underflow attempt is unreachable and needs no handling.
- Reset mid-packet: the packet is truncated downstream. Reset is system-wide, so no recovery protocol exists.
- Invariant: free_slot_count + popcount(busy bitmap) == SLOT_COUNT after INIT.

Test Plan:
- Reset, then 20 idle cycles -> init_done rises exactly SLOT_COUNT(16) cycles after reset deasserts; free_slot_count=16; slot_err=0.
- One 3-beat packet, tuser=2, tready=1 -> 3 beats out with tdest=1 and tuser=2, data unchanged; free_slot_count=15; one bubble cycle before the first beat.
- 17 single-beat packets, no release -> tdest=1..16 in order; the 17th stalls with s_axis_tready=0 and count=0. Release slot 5 -> the 17th exits with tdest=5.
- Release slot 3 while it is free, then release slot 0, then slot 17 -> slot_err=1 after the first; free_slot_count unchanged; a type 4'h1 message sets no error.
- 4-beat packet with m_axis_tready toggling 1,0,0,1,... -> all 4 beats delivered in order; tdest held at cur_slot on every beat; s_axis_tready mirrors m_axis_tready.
- Release slot 2 in the same cycle IDLE pops a slot with count=1 -> count stays 1; slot 2 is at the FIFO tail; the next packet gets the previous head.
